// File: rtl/cam_ctrl.sv
// Camera sensor controller: sequences pixel erase, exposure and a two-row
// readout with ADC strobes, and holds the exposure setting sent to the timer.
module cam_ctrl #(
  parameter int unsigned EX_MIN   = 2,
  parameter int unsigned EX_MAX   = 30,
  parameter int unsigned EX_RESET = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Init,
  input  logic       Ex_increase,
  input  logic       Ex_decrease,
  input  logic       Ovf5,
  output logic       Start,
  output logic [4:0] EX_time,
  output logic       Erase,
  output logic       Expose,
  output logic       NRE_1,
  output logic       NRE_2,
  output logic       ADC,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXPOSURE = 2'd1,
    READOUT  = 2'd2
  } state_t;

  localparam logic [4:0] EX_MIN_C   = 5'(EX_MIN);
  localparam logic [4:0] EX_MAX_C   = 5'(EX_MAX);
  localparam logic [4:0] EX_RESET_C = 5'(EX_RESET);

  state_t     state_q, state_d;
  logic [2:0] phase_q, phase_d, phase_nx;
  logic [4:0] ex_q, ex_d;
  logic       hold_q, hold_d;
  logic       start_q, start_d;
  logic       erase_q, erase_d;
  logic       expose_q, expose_d;
  logic       nre1_q, nre1_d;
  logic       nre2_q, nre2_d;
  logic       adc_q, adc_d;

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    phase_nx = phase_q + 3'd1;
    ex_d     = ex_q;
    hold_d   = 1'b0;
    start_d  = 1'b0;
    erase_d  = erase_q;
    expose_d = expose_q;
    nre1_d   = 1'b1;
    nre2_d   = 1'b1;
    adc_d    = 1'b0;
    case (state_q)
      IDLE: begin
        erase_d  = 1'b1;
        expose_d = 1'b0;
        // hold_q masks Init for the first edge after reset is released
        if (Init && !hold_q) begin
          state_d  = EXPOSURE;
          start_d  = 1'b1;
          expose_d = 1'b1;
          erase_d  = 1'b0;
        end else if (Ex_increase && !Ex_decrease && (ex_q < EX_MAX_C)) begin
          ex_d = ex_q + 5'd1;
        end else if (Ex_decrease && !Ex_increase && (ex_q > EX_MIN_C)) begin
          ex_d = ex_q - 5'd1;
        end
      end
      EXPOSURE: begin
        expose_d = 1'b1;
        erase_d  = 1'b0;
        if (Ovf5) begin
          state_d  = READOUT;
          phase_d  = 3'd0;
          expose_d = 1'b0;
          nre1_d   = 1'b0;
        end
      end
      READOUT: begin
        expose_d = 1'b0;
        erase_d  = 1'b0;
        if (phase_q == 3'd6) begin
          state_d = IDLE;
          phase_d = 3'd0;
          erase_d = 1'b1;
        end else begin
          // outputs are registered, so decode the phase being entered
          phase_d = phase_nx;
          nre1_d  = !(phase_nx <= 3'd2);
          nre2_d  = !(phase_nx >= 3'd4);
          adc_d   = (phase_nx == 3'd1) || (phase_nx == 3'd5);
        end
      end
      default: begin
        state_d  = IDLE;
        phase_d  = 3'd0;
        erase_d  = 1'b1;
        expose_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      phase_q  <= 3'd0;
      ex_q     <= EX_RESET_C;
      hold_q   <= 1'b1;
      start_q  <= 1'b0;
      erase_q  <= 1'b1;
      expose_q <= 1'b0;
      nre1_q   <= 1'b1;
      nre2_q   <= 1'b1;
      adc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      ex_q     <= ex_d;
      hold_q   <= hold_d;
      start_q  <= start_d;
      erase_q  <= erase_d;
      expose_q <= expose_d;
      nre1_q   <= nre1_d;
      nre2_q   <= nre2_d;
      adc_q    <= adc_d;
    end
  end

  assign Start     = start_q;
  assign EX_time   = ex_q;
  assign Erase     = erase_q;
  assign Expose    = expose_q;
  assign NRE_1     = nre1_q;
  assign NRE_2     = nre2_q;
  assign ADC       = adc_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cam_ctrl.sv
// Directed bench for cam_ctrl: each driven edge pushes the expected output
// word into a queue; a monitor pops and compares one word per edge.
module tb_cam_ctrl;

  localparam int W = 13;

  logic       clk = 1'b0;
  logic       rst, init, inc, dec, ovf;
  logic       start, erase, expose, nre1, nre2, adc;
  logic [4:0] ex_time;
  logic [1:0] dbg_state;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  // {nre1, nre2, adc} for readout phases R0..R6
  logic [2:0] rd_tab [7] = '{3'b010, 3'b011, 3'b010, 3'b110,
                             3'b100, 3'b101, 3'b100};

  always #5 clk = ~clk;

  cam_ctrl #(.EX_MIN(2), .EX_MAX(30), .EX_RESET(2)) dut (
    .Clk(clk), .Reset(rst), .Init(init), .Ex_increase(inc),
    .Ex_decrease(dec), .Ovf5(ovf), .Start(start), .EX_time(ex_time),
    .Erase(erase), .Expose(expose), .NRE_1(nre1), .NRE_2(nre2),
    .ADC(adc), .dbg_state(dbg_state)
  );

  function automatic logic [W-1:0] ov(input logic [1:0] st, input logic s,
      input logic e, input logic er, input logic n1, input logic n2,
      input logic a, input logic [4:0] ex);
    return {st, s, e, er, n1, n2, a, ex};
  endfunction

  function automatic logic [W-1:0] idle_v(input logic [4:0] ex);
    return ov(2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, ex);
  endfunction

  function automatic logic [W-1:0] expo_v(input logic s, input logic [4:0] ex);
    return ov(2'd1, s, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, ex);
  endfunction

  function automatic logic [W-1:0] rd_v(input int p, input logic [4:0] ex);
    logic [2:0] t;
    t = rd_tab[p];
    return ov(2'd2, 1'b0, 1'b0, 1'b0, t[2], t[1], t[0], ex);
  endfunction

  // Drive one edge's inputs and queue the outputs expected after that edge.
  task automatic step(input logic r, input logic i, input logic up,
      input logic dn, input logic o, input logic [W-1:0] e, input string nm);
    rst  = r;
    init = i;
    inc  = up;
    dec  = dn;
    ovf  = o;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    logic [W-1:0] got, want;
    string nm;
    #1;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      nm   = name_q.pop_front();
      got  = {dbg_state, start, expose, erase, nre1, nre2, adc, ex_time};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s got=%b expected=%b", nm, got, want);
      end
    end
  end

  initial begin
    logic [4:0] ex;
    rst = 1'b0; init = 1'b0; inc = 1'b0; dec = 1'b0; ovf = 1'b0;
    @(negedge clk);

    step(1, 0, 0, 0, 0, idle_v(2), "reset");
    step(1, 0, 0, 0, 0, idle_v(2), "reset_held");
    step(0, 1, 0, 0, 0, idle_v(2), "init_ignored_after_reset");
    step(0, 1, 0, 0, 0, expo_v(1, 2), "start_pulse");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, expo_v(0, 2), "expose_hold");
    step(0, 0, 0, 0, 1, rd_v(0, 2), "ovf_to_r0");
    for (int p = 1; p < 7; p++) step(0, 0, 0, 0, 0, rd_v(p, 2), "readout_phase");
    step(0, 0, 0, 0, 0, idle_v(2), "back_to_idle");
    step(0, 0, 0, 0, 1, idle_v(2), "stray_ovf_idle");

    ex = 5'd2;
    for (int i = 0; i < 40; i++) begin
      if (ex < 5'd30) ex = ex + 5'd1;
      step(0, 0, 1, 0, 0, idle_v(ex), "ex_inc_sat");
    end
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, idle_v(30), "ex_both_hold_max");
    for (int i = 0; i < 40; i++) begin
      if (ex > 5'd2) ex = ex - 5'd1;
      step(0, 0, 0, 1, 0, idle_v(ex), "ex_dec_sat");
    end
    for (int i = 0; i < 8; i++) begin
      ex = ex + 5'd1;
      step(0, 0, 1, 0, 0, idle_v(ex), "ex_inc_to_10");
    end
    step(0, 0, 1, 1, 0, idle_v(10), "ex_both_hold_10");

    step(0, 1, 1, 0, 0, expo_v(1, 10), "init_priority");
    for (int i = 0; i < 4; i++)
      step(0, 1, i[0], !i[0], 0, expo_v(0, 10), "lockout_expose");
    step(0, 1, 1, 0, 1, rd_v(0, 10), "lockout_r0");
    for (int p = 1; p < 7; p++)
      step(0, 1, p[0], 0, (p == 4), rd_v(p, 10), "readout_stray_ovf");
    step(0, 1, 0, 0, 0, idle_v(10), "lockout_idle");
    step(0, 1, 0, 0, 0, expo_v(1, 10), "retrigger");
    step(0, 1, 0, 0, 0, expo_v(0, 10), "single_start");

    step(0, 0, 0, 0, 1, rd_v(0, 10), "abort_r0");
    step(0, 0, 0, 0, 0, rd_v(1, 10), "abort_r1");
    step(1, 0, 0, 0, 0, idle_v(2), "abort_readout");
    step(0, 1, 0, 0, 0, idle_v(2), "abort_init_ignored");
    step(0, 1, 0, 0, 0, expo_v(1, 2), "restart");
    step(1, 0, 0, 0, 0, idle_v(2), "abort_expose");
    step(0, 0, 0, 0, 0, idle_v(2), "idle_final");

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
